// File: rtl/demux4_buf_if.sv
// Bundles the producer-side and consumer-side handshake signals of demux4_buf.
// The slave modport is the demux; the master modport drives the producer
// inputs and the consumer ready lines.
interface demux4_buf_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [WIDTH-1:0]   out_data0;
  logic [WIDTH-1:0]   out_data1;
  logic [WIDTH-1:0]   out_data2;
  logic [WIDTH-1:0]   out_data3;
  logic [4*CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           out_count
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
           out_count
  );
endinterface

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer. Each output channel owns a one-entry
// holding register plus a wrapping delivery counter. A channel can take a new
// word in the same cycle its current word drains, so a channel with ready held
// high sustains one word per cycle. The only combinational path is
// out_ready/in_sel -> in_ready.
module demux4_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  demux4_buf_if.slave  bus
);

  logic [3:0]       full_q, full_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];
  logic [3:0]       drain;
  logic             accept;

  // Ready depends only on the target channel's occupancy and its consumer,
  // never on in_valid, so the producer may use it to decide whether to assert.
  assign bus.in_ready = ~full_q[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = full_q & bus.out_ready;

  // Next-state for every channel: independent drains, at most one accept.
  always_comb begin
    full_d = full_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i] + CNT_W'(drain[i]);
      if (drain[i]) begin
        full_d[i] = 1'b0;
      end
      // An accept in the drain cycle overrides the clear, keeping the channel full.
      if (accept && (bus.in_sel == 2'(i))) begin
        full_d[i] = 1'b1;
        data_d[i] = bus.in_data;
      end
    end
  end

  // Channel state registers; reset discards held words and zeroes counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign bus.out_valid = full_q;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];
  assign bus.out_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_demux4_buf.sv
// Scoreboard bench for demux4_buf: the stimulus pushes each word it expects
// accepted into its channel's queue; a negedge monitor pops and compares on
// every drain the DUT presents.
module tb_demux4_buf;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux4_buf_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q [4][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] data_of(input int ch);
    case (ch)
      0:       return bus.out_data0;
      1:       return bus.out_data1;
      2:       return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  // Monitor: any channel presenting valid with ready high drains at the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.out_valid[i] && bus.out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("drain_spurious_ch%0d", i), 64'(data_of(i)), 64'hX);
          end else begin
            logic [WIDTH-1:0] w;
            w = exp_q[i].pop_front();
            check($sformatf("drain_data_ch%0d", i), 64'(data_of(i)), 64'(w));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word; in_ready is checked against the hand-expected value and the
  // word is queued only if it is expected to be accepted.
  task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] d, input logic exp_rdy,
                      input string name);
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    #1;
    check(name, 64'(bus.in_ready), 64'(exp_rdy));
    if (exp_rdy) exp_q[sel].push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 4'b0000;

    // Reset then idle
    do_reset();
    step();
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_data0", 64'(bus.out_data0), 64'h0);
    check("rst_data1", 64'(bus.out_data1), 64'h0);
    check("rst_data2", 64'(bus.out_data2), 64'h0);
    check("rst_data3", 64'(bus.out_data3), 64'h0);
    check("rst_count", 64'(bus.out_count), 64'h0);
    for (int s = 0; s < 4; s++) begin
      bus.in_sel = 2'(s);
      #1;
      check($sformatf("rst_in_ready_sel%0d", s), 64'(bus.in_ready), 64'h1);
    end

    // Routing
    send(2'd2, 32'hDEADBEEF, 1'b1, "route_in_ready");
    step();
    bus.in_valid = 1'b0;
    check("route_out_valid", 64'(bus.out_valid), 64'h4);
    check("route_data2", 64'(bus.out_data2), 64'hDEADBEEF);
    check("route_data0", 64'(bus.out_data0), 64'h0);
    check("route_data1", 64'(bus.out_data1), 64'h0);
    check("route_data3", 64'(bus.out_data3), 64'h0);
    check("route_count", 64'(bus.out_count), 64'h0);
    bus.in_sel = 2'd2;
    #1;
    check("route_ready_sel2_full", 64'(bus.in_ready), 64'h0);
    bus.in_sel = 2'd0;
    #1;
    check("route_ready_sel0", 64'(bus.in_ready), 64'h1);
    bus.out_ready = 4'b0100;
    step();
    bus.out_ready = 4'b0000;
    check("route_count_after_drain", 64'(bus.out_count), 64'h0001_0000);
    check("route_valid_after_drain", 64'(bus.out_valid), 64'h0);

    // Stall and pass-through on channel 1
    send(2'd1, 32'h11, 1'b1, "pt_first_ready");
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0010;
    send(2'd1, 32'h22, 1'b1, "pt_in_ready");
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    check("pt_out_valid1", 64'(bus.out_valid[1]), 64'h1);
    check("pt_data1", 64'(bus.out_data1), 64'h22);
    check("pt_cnt1", 64'(bus.out_count[CNT_W +: CNT_W]), 64'h1);
    bus.out_ready = 4'b0010;
    step();
    bus.out_ready = 4'b0000;
    send(2'd1, 32'h33, 1'b1, "stall_first_ready");
    step();
    send(2'd1, 32'h44, 1'b0, "stall_in_ready");
    step();
    send(2'd1, 32'h44, 1'b0, "stall_in_ready_hold");
    step();
    check("stall_data1_stable", 64'(bus.out_data1), 64'h33);
    bus.in_sel = 2'd0;
    #1;
    check("stall_other_ch_ready", 64'(bus.in_ready), 64'h1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0010;
    step();
    bus.out_ready = 4'b0000;
    check("stall_cnt1", 64'(bus.out_count[CNT_W +: CNT_W]), 64'h3);

    // Parallel traffic from a clean start
    do_reset();
    for (int c = 0; c < 4; c++) begin
      send(2'(c), 32'hA0 + 32'(c), 1'b1, $sformatf("par_ready_ch%0d", c));
      step();
    end
    bus.in_valid = 1'b0;
    check("par_all_full", 64'(bus.out_valid), 64'hF);
    bus.out_ready = 4'b1111;
    step();
    bus.out_ready = 4'b0000;
    check("par_out_valid", 64'(bus.out_valid), 64'h0);
    check("par_counts", 64'(bus.out_count), 64'h0101_0101);

    // Counter wrap on channel 3 with ready held high
    do_reset();
    bus.out_ready = 4'b1000;
    for (int k = 0; k < 255; k++) begin
      send(2'd3, 32'h3000 + 32'(k), 1'b1, "wrap_in_ready");
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("wrap_cnt3_255", 64'(bus.out_count[3*CNT_W +: CNT_W]), 64'hFF);
    send(2'd3, 32'h3FFF, 1'b1, "wrap_last_ready");
    step();
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 4'b0000;
    check("wrap_cnt3_256", 64'(bus.out_count[3*CNT_W +: CNT_W]), 64'h00);

    // Reset mid-operation
    bus.out_ready = 4'b0100;
    send(2'd2, 32'h55, 1'b1, "mid_ch2_ready");
    step();
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 4'b0000;
    send(2'd0, 32'h66, 1'b1, "mid_ch0_ready");
    step();
    send(2'd1, 32'h77, 1'b1, "mid_ch1_ready");
    step();
    check("mid_pre_valid", 64'(bus.out_valid), 64'h3);
    check("mid_pre_count", 64'(bus.out_count), 64'h0001_0000);
    rst           = 1'b1;
    bus.in_sel    = 2'd3;
    bus.in_data   = 32'h99;
    bus.in_valid  = 1'b1;
    bus.out_ready = 4'b1111;
    step();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    check("mid_out_valid", 64'(bus.out_valid), 64'h0);
    check("mid_count", 64'(bus.out_count), 64'h0);
    check("mid_data3", 64'(bus.out_data3), 64'h0);
    check("mid_data0", 64'(bus.out_data0), 64'h0);
    step();
    check("mid_out_valid_later", 64'(bus.out_valid), 64'h0);

    for (int i = 0; i < 4; i++)
      check($sformatf("scoreboard_empty_ch%0d", i), 64'(exp_q[i].size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
